// File: rtl/active_lamps_pkg.sv
// Shared constants and target arithmetic for the multi-room lamp controller.
package active_lamps_pkg;

    localparam logic [3:0] TC_MORNING = 4'b0001;
    localparam logic [3:0] TC_NOON    = 4'b0010;
    localparam logic [3:0] TC_EVENING = 4'b0100;
    localparam logic [3:0] TC_NIGHT   = 4'b1000;

    // Evening lights a quarter of the floor area; night follows the user. Both are capped.
    function automatic logic [31:0] calc_target(
        input logic [3:0]  tcode,
        input logic [31:0] ulight,
        input logic [31:0] length,
        input logic [31:0] max_lights
    );
        logic [31:0] area_s;
        logic [31:0] raw_s;
        area_s = (length * length) >> 32'd2;
        case (tcode)
            TC_EVENING: raw_s = area_s;
            TC_NIGHT:   raw_s = ulight;
            default:    raw_s = 32'd0;
        endcase
        calc_target = (raw_s > max_lights) ? max_lights : raw_s;
    endfunction

    function automatic logic tcode_legal(input logic [3:0] tcode);
        case (tcode)
            TC_MORNING, TC_NOON, TC_EVENING, TC_NIGHT: tcode_legal = 1'b1;
            default:                                   tcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/active_lamps_ctrl_lamp_ramp.sv
// One room: stored target, driven lamp count stepping one lamp per tick, settled flag.
module lamp_ramp #(
    parameter int LIGHT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               wr_en,
    input  logic [LIGHT_W-1:0] wr_target,
    output logic [LIGHT_W-1:0] current,
    output logic               settled
);

    logic [LIGHT_W-1:0] target_r;
    logic [LIGHT_W-1:0] current_r;
    logic               settled_r;
    logic [LIGHT_W-1:0] target_nxt_s;
    logic [LIGHT_W-1:0] current_nxt_s;

    // Next-state: a tick steps against the target held before any write this cycle.
    always_comb begin
        current_nxt_s = current_r;
        if (tick && (current_r < target_r)) begin
            current_nxt_s = current_r + {{(LIGHT_W-1){1'b0}}, 1'b1};
        end else if (tick && (current_r > target_r)) begin
            current_nxt_s = current_r - {{(LIGHT_W-1){1'b0}}, 1'b1};
        end else begin
            current_nxt_s = current_r;
        end
        if (wr_en) begin
            target_nxt_s = wr_target;
        end else begin
            target_nxt_s = target_r;
        end
    end

    // State registers; settled is registered from the next-state values so it tracks them exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r  <= {LIGHT_W{1'b0}};
            current_r <= {LIGHT_W{1'b0}};
            settled_r <= 1'b1;
        end else begin
            target_r  <= target_nxt_s;
            current_r <= current_nxt_s;
            settled_r <= (current_nxt_s == target_nxt_s);
        end
    end

    assign current = current_r;
    assign settled = settled_r;

endmodule

// File: rtl/active_lamps_ctrl.sv
// Multi-room lamp controller: request handshake, target computation, shared ramp prescaler, sticky errors.
module active_lamps_ctrl
    import active_lamps_pkg::*;
#(
    parameter  int NUM_ROOMS  = 4,
    parameter  int LEN_W      = 4,
    parameter  int LIGHT_W    = 8,
    parameter  int MAX_LIGHTS = 64,
    parameter  int RAMP_DIV   = 4,
    localparam int RIDX_W     = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [RIDX_W-1:0]            req_room,
    input  logic [3:0]                   req_tcode,
    input  logic [LIGHT_W-1:0]           req_ulight,
    input  logic [LEN_W-1:0]             req_length,
    output logic [NUM_ROOMS*LIGHT_W-1:0] lights,
    output logic [NUM_ROOMS-1:0]         settled,
    output logic                         err_tcode,
    output logic                         err_room,
    input  logic                         err_clr
);

    localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(RAMP_DIV - 1);
    localparam logic [RIDX_W:0]   ROOMS_LIM = (RIDX_W + 1)'(NUM_ROOMS);

    logic                 ready_r;
    logic                 s1_valid_r;
    logic [RIDX_W-1:0]    s1_room_r;
    logic [3:0]           s1_tcode_r;
    logic [LIGHT_W-1:0]   s1_ulight_r;
    logic [LEN_W-1:0]     s1_length_r;
    logic [PS_W-1:0]      ps_cnt_r;
    logic                 err_tcode_r;
    logic                 err_room_r;

    logic                 tick_s;
    logic                 room_ok_s;
    logic                 set_tcode_s;
    logic                 set_room_s;
    logic [LIGHT_W-1:0]   target_s;

    assign tick_s      = (ps_cnt_r == PS_LAST);
    assign room_ok_s   = ({1'b0, s1_room_r} < ROOMS_LIM);
    assign set_room_s  = s1_valid_r && !room_ok_s;
    assign set_tcode_s = s1_valid_r && room_ok_s && !tcode_legal(s1_tcode_r);
    assign target_s    = LIGHT_W'(calc_target(s1_tcode_r, 32'(s1_ulight_r),
                                              32'(s1_length_r), 32'(MAX_LIGHTS)));

    // Handshake readiness and stage-1 capture of an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r     <= 1'b0;
            s1_valid_r  <= 1'b0;
            s1_room_r   <= {RIDX_W{1'b0}};
            s1_tcode_r  <= 4'b0000;
            s1_ulight_r <= {LIGHT_W{1'b0}};
            s1_length_r <= {LEN_W{1'b0}};
        end else begin
            ready_r    <= 1'b1;
            s1_valid_r <= req_valid && ready_r;
            if (req_valid && ready_r) begin
                s1_room_r   <= req_room;
                s1_tcode_r  <= req_tcode;
                s1_ulight_r <= req_ulight;
                s1_length_r <= req_length;
            end else begin
                s1_room_r   <= s1_room_r;
                s1_tcode_r  <= s1_tcode_r;
                s1_ulight_r <= s1_ulight_r;
                s1_length_r <= s1_length_r;
            end
        end
    end

    // Free-running ramp prescaler shared by all rooms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            ps_cnt_r <= {PS_W{1'b0}};
        end else begin
            ps_cnt_r <= ps_cnt_r + {{(PS_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tcode_r <= 1'b0;
            err_room_r  <= 1'b0;
        end else begin
            err_tcode_r <= set_tcode_s || (err_tcode_r && !err_clr);
            err_room_r  <= set_room_s  || (err_room_r  && !err_clr);
        end
    end

    generate
        for (genvar r = 0; r < NUM_ROOMS; r++) begin : g_room
            logic               wr_en_s;
            logic [LIGHT_W-1:0] cur_s;
            assign wr_en_s = s1_valid_r && room_ok_s && (s1_room_r == RIDX_W'(r));
            lamp_ramp #(.LIGHT_W(LIGHT_W)) u_ramp (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick_s),
                .wr_en     (wr_en_s),
                .wr_target (target_s),
                .current   (cur_s),
                .settled   (settled[r])
            );
            assign lights[r*LIGHT_W +: LIGHT_W] = cur_s;
        end
    endgenerate

    assign req_ready = ready_r;
    assign err_tcode = err_tcode_r;
    assign err_room  = err_room_r;

endmodule

// File: tb/tb_active_lamps_ctrl.sv
// Randomized and directed bench for active_lamps_ctrl against a per-cycle behavioural room model.
module tb_active_lamps_ctrl;

    localparam int NR = 3;
    localparam int LW = 4;
    localparam int GW = 8;
    localparam int ML = 64;
    localparam int RD = 4;
    localparam int RW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [RW-1:0]     req_room = '0;
    logic [3:0]        req_tcode = 4'b0000;
    logic [GW-1:0]     req_ulight = '0;
    logic [LW-1:0]     req_length = '0;
    logic [NR*GW-1:0]  lights;
    logic [NR-1:0]     settled;
    logic              err_tcode;
    logic              err_room;
    logic              err_clr = 1'b0;

    active_lamps_ctrl #(
        .NUM_ROOMS(NR), .LEN_W(LW), .LIGHT_W(GW), .MAX_LIGHTS(ML), .RAMP_DIV(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_room(req_room), .req_tcode(req_tcode), .req_ulight(req_ulight),
        .req_length(req_length), .lights(lights), .settled(settled),
        .err_tcode(err_tcode), .err_room(err_room), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: per-room target and lamp count, one-deep accepted-request slot.
    int m_cur[NR];
    int m_tgt[NR];
    int m_cyc;
    bit m_ready, m_et, m_er;
    bit p_v;
    int p_room, p_tc, p_ul, p_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_target(input int tc, input int ul, input int len);
        int v;
        if (tc == 4)      v = (len * len) / 4;
        else if (tc == 8) v = ul;
        else              v = 0;
        return (v > ML) ? ML : v;
    endfunction

    function automatic bit legal(input int tc);
        return (tc == 1) || (tc == 2) || (tc == 4) || (tc == 8);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_cur[r] = 0;
            m_tgt[r] = 0;
        end
        m_cyc = 0; m_ready = 0; m_et = 0; m_er = 0; p_v = 0;
    endtask

    task automatic model_edge();
        bit nt, nr;
        nt = 0; nr = 0;
        if (m_cyc % RD == RD - 1) begin
            for (int r = 0; r < NR; r++) begin
                if (m_cur[r] < m_tgt[r])      m_cur[r]++;
                else if (m_cur[r] > m_tgt[r]) m_cur[r]--;
            end
        end
        if (p_v) begin
            if (p_room >= NR) nr = 1;
            else begin
                m_tgt[p_room] = ref_target(p_tc, p_ul, p_len);
                nt = !legal(p_tc);
            end
        end
        m_et = nt || (m_et && !err_clr);
        m_er = nr || (m_er && !err_clr);
        p_v = req_valid && m_ready;
        p_room = int'(req_room); p_tc = int'(req_tcode);
        p_ul = int'(req_ulight); p_len = int'(req_length);
        m_ready = 1;
        m_cyc++;
    endtask

    task automatic check_all();
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("lights%0d", r), 32'(lights[r*GW +: GW]), 32'(m_cur[r]));
            chk($sformatf("settled%0d", r), 32'(settled[r]), 32'(m_cur[r] == m_tgt[r]));
        end
        chk("err_tcode", 32'(err_tcode), 32'(m_et));
        chk("err_room", 32'(err_room), 32'(m_er));
        chk("req_ready", 32'(req_ready), 32'(m_ready));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int room, input int tc, input int ul, input int len);
        req_valid = 1'b1;
        req_room = RW'(room); req_tcode = 4'(tc);
        req_ulight = GW'(ul); req_length = LW'(len);
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycle();

        // Evening, side 10: ramp up to 25.
        send(0, 4, 0, 10);
        idle(110);
        chk("ev25_lights", 32'(lights[GW-1:0]), 32'd25);
        chk("ev25_settled", 32'(settled[0]), 32'd1);

        // Night request above the cap, then ramp back down with morning.
        send(1, 8, 200, 0);
        idle(270);
        chk("night_cap", 32'(lights[2*GW-1:GW]), 32'd64);
        send(1, 1, 0, 0);
        idle(270);
        chk("morning_zero", 32'(lights[2*GW-1:GW]), 32'd0);

        // Illegal time code, clear, then clear racing a new error.
        send(2, 6, 30, 9);
        idle(1);
        chk("tcode_err_set", 32'(err_tcode), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("tcode_err_clr", 32'(err_tcode), 32'd0);
        err_clr = 1'b1;
        send(2, 3, 0, 0);
        cycle();
        err_clr = 1'b0;
        chk("tcode_set_wins", 32'(err_tcode), 32'd1);

        // Out-of-range room is dropped.
        send(3, 4, 0, 15);
        idle(2);
        chk("room_err", 32'(err_room), 32'd1);

        // Back-to-back to room 0, second target write lands on a tick.
        while (m_cyc % RD != (2 * RD - 3) % RD) cycle();
        send(0, 4, 0, 4);
        send(0, 8, 9, 0);
        idle(120);
        chk("b2b_last_wins", 32'(lights[GW-1:0]), 32'd9);

        // Reset mid-ramp.
        send(0, 4, 0, 10);
        for (int i = 0; i < 200 && m_cur[0] != 12; i++) cycle();
        chk("mid_ramp12", 32'(lights[GW-1:0]), 32'd12);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_lights0", 32'(lights[GW-1:0]), 32'd0);
        chk("rst_ready0", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        m_cyc = 0;
        model_reset();
        // The edge just taken counts as the first post-reset edge.
        m_ready = 1; m_cyc = 1;
        check_all();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int pick;
            int tc;
            pick = $urandom_range(0, 9);
            tc = (pick < 8) ? (1 << (pick % 4)) : int'($urandom_range(0, 15));
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) begin
                send(int'($urandom_range(0, 3)), tc, int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 15)));
            end else begin
                cycle();
            end
        end
        err_clr = 1'b0;
        idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
